// File: rtl/puf_resp_seq.sv
// rtl/puf_resp_seq.sv - Ring-oscillator PUF response sequencer: measure, compare and pack N_BITS response bits.
module puf_resp_seq #(
    parameter int WIN_CYCLES    = 1024,
    parameter int SETTLE_CYCLES = 4,
    parameter int N_BITS        = 16,
    parameter int CW            = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4:0]        challenge_base,
    output logic              osc_ena,
    output logic              cnt_clr,
    output logic [4:0]        challenge,
    input  logic [CW-1:0]     count1,
    input  logic [CW-1:0]     count2,
    output logic [N_BITS-1:0] resp,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              busy,
    output logic              tie
);

    localparam int TMAX = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [4:0] IDX_LAST = 5'(N_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        MEASURE,
        SETTLE,
        COMPARE,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] tmr;
    logic [4:0]    idx;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = CLEAR;
            CLEAR:   state_nxt = MEASURE;
            MEASURE: if (tmr == '0) state_nxt = SETTLE;
            SETTLE:  if (tmr == '0) state_nxt = COMPARE;
            COMPARE: state_nxt = (idx == IDX_LAST) ? DONE : CLEAR;
            DONE:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= IDLE;
            tmr        <= '0;
            idx        <= '0;
            osc_ena    <= 1'b0;
            cnt_clr    <= 1'b0;
            challenge  <= '0;
            resp       <= '0;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            tie        <= 1'b0;
        end else begin
            state      <= state_nxt;
            osc_ena    <= (state_nxt == MEASURE);
            cnt_clr    <= (state_nxt == CLEAR);
            busy       <= (state_nxt != IDLE);
            resp_valid <= (state_nxt == DONE);

            case (state)
                IDLE: begin
                    if (start) begin
                        challenge <= challenge_base;
                        idx       <= '0;
                        resp      <= '0;
                        tie       <= 1'b0;
                    end
                end
                CLEAR: tmr <= TW'(WIN_CYCLES - 1);
                MEASURE: begin
                    if (tmr == '0) tmr <= TW'(SETTLE_CYCLES - 1);
                    else           tmr <= tmr - 1'b1;
                end
                SETTLE: begin
                    if (tmr != '0) tmr <= tmr - 1'b1;
                end
                COMPARE: begin
                    // resp is cleared at start, so OR-ing in the new bit is enough; ties give 0.
                    resp <= resp | (N_BITS'(count1 > count2) << idx);
                    tie  <= tie | (count1 == count2);
                    if (idx != IDX_LAST) begin
                        idx       <= idx + 5'd1;
                        challenge <= challenge + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/puf_resp_seq.md
PUF_RESP_SEQ -- requirements
Module: puf_resp_seq

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- WIN_CYCLES, 1024: clk cycles the oscillators are enabled per measurement.
- SETTLE_CYCLES, 4: clk cycles after disable before counts are sampled.
- N_BITS, 16: response bits per run, legal range 1..32.
- CW, 16: counter width.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  sole clock.
- rst_n  in  1  reset; one clock; reset is synchronous and active-high (rst_n=1 resets).
- start  in  1  request a response run; sampled only in IDLE.
- challenge_base  in  5  first challenge of the run; captured when start is accepted.
- osc_ena  out  1  enable to both oscillator banks.
- cnt_clr  out  1  clear pulse to both counters.
- challenge  out  5  mux select driven to both banks.
- count1  in  CW  bank-1 counter value.
- count2  in  CW  bank-2 counter value.
- resp  out  N_BITS  response word.
- resp_valid  out  1  resp is valid.
- resp_ready  in  1  consumer accepts resp.
- busy  out  1  high in every state except IDLE.
- tie  out  1  sticky: at least one compare in this run had count1==count2.

Function
REQ-003 The FSM SHALL have the states IDLE, CLEAR, MEASURE, SETTLE, COMPARE and DONE.
REQ-004 In IDLE, start=1 SHALL capture challenge_base, set idx=0, clear resp and tie, and enter CLEAR on the next cycle.
REQ-005 CLEAR SHALL last 1 cycle with cnt_clr=1 and osc_ena=0, then enter MEASURE.
REQ-006 MEASURE SHALL last exactly WIN_CYCLES cycles with osc_ena=1 and cnt_clr=0, then enter SETTLE.
REQ-007 SETTLE SHALL last exactly SETTLE_CYCLES cycles with osc_ena=0, then enter COMPARE.
REQ-008 COMPARE SHALL last 1 cycle and SHALL write resp[idx] = (count1 > count2), an unsigned CW-bit compare.
REQ-009 In COMPARE, count1==count2 SHALL write a 0 bit and set tie; tie SHALL hold until the next accepted start or reset.
REQ-010 From COMPARE, if idx==N_BITS-1 the FSM SHALL enter DONE; otherwise it SHALL increment idx and enter CLEAR.
REQ-011 The challenge output SHALL equal (captured challenge_base + idx) mod 32, wrapping 31 to 0.
REQ-012 The challenge output SHALL be stable from CLEAR through COMPARE of each bit.
REQ-013 In IDLE, challenge SHALL hold its last value.
REQ-014 Each bit SHALL take W+S+2 cycles (W = WIN_CYCLES, S = SETTLE_CYCLES).
REQ-015 The first resp_valid=1 cycle SHALL occur N_BITS*(W+S+2)+1 cycles after the cycle in which start was sampled high.
REQ-016 In DONE, resp_valid=1 and resp SHALL be held stable until resp_ready=1.
REQ-017 On the cycle where resp_valid=1 and resp_ready=1, the FSM SHALL return to IDLE and resp_valid SHALL be 0 on the next cycle.
REQ-018 resp and tie SHALL hold their values after the DONE-to-IDLE handshake.
REQ-019 start SHALL be ignored in every state except IDLE, including DONE.
REQ-020 start=1 in IDLE on the cycle immediately after the handshake SHALL begin a new run.
REQ-021 osc_ena SHALL be 1 only in MEASURE, and cnt_clr SHALL be 1 only in CLEAR.
REQ-022 All outputs SHALL be registered.

Reset
REQ-023 rst_n=1 at a clk edge SHALL force IDLE with osc_ena=0, cnt_clr=0, challenge=0, resp=0, resp_valid=0, busy=0, tie=0 and idx=0.
REQ-024 A reset asserted mid-run, in any state, SHALL abort the run with no partial resp_valid.
REQ-025 start SHALL be ignored while rst_n=1.

Verification (WIN_CYCLES=8, SETTLE_CYCLES=2, N_BITS=4)
REQ-026 Basic run: start with base=0; counts sampled at each COMPARE are (100,90), (50,60), (70,70), (200,10) -> resp=4'b1001, tie=1, challenge sequence 0,1,2,3, resp_valid first high 49 cycles after start.
REQ-027 Challenge wrap: base=30 -> challenge sequence 30,31,0,1.
REQ-028 Backpressure: resp_ready held low 20 cycles in DONE -> resp and resp_valid stable throughout; start pulses during DONE are ignored; resp_ready=1 -> IDLE on the next cycle, busy=0.
REQ-029 Reset mid-MEASURE of bit 2 -> next cycle all outputs at reset values; a following start gives a full, correct 4-bit run.
REQ-030 Timing check: in every bit, exactly 1 cnt_clr cycle and exactly 8 contiguous osc_ena cycles, with no overlap; count1=count2=0xFFFF -> bit 0 and tie=1.
